// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//   MIPS general-purpose register file: DEPTH x WIDTH storage with one
//   synchronous write port and two combinational read ports. Register 0 is
//   hard-wired to zero. A write being presented in the current cycle is
//   forwarded to any read port addressing the same register, so a writeback
//   in cycle N is visible to a decode read in that same cycle N.
//
// Ports
//   Clk      in   1       system clock, state updates on the rising edge
//   Reset    in   1       asynchronous active-low reset, clears all registers
//   WrEn     in   1       write enable, sampled on the rising Clk edge
//   WrAddr   in   ADDR_W  write register index
//   WrData   in   WIDTH   write data
//   RdAddrA  in   ADDR_W  read port A index (rs)
//   RdAddrB  in   ADDR_W  read port B index (rt)
//   RdDataA  out  WIDTH   read port A data, combinational
//   RdDataB  out  WIDTH   read port B data, combinational
// ---------------------------------------------------------------------------
module register_file #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,   // must equal 2**ADDR_W
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [WIDTH-1:0]  WrData,
    input  logic [ADDR_W-1:0] RdAddrA,
    input  logic [ADDR_W-1:0] RdAddrB,
    output logic [WIDTH-1:0]  RdDataA,
    output logic [WIDTH-1:0]  RdDataB
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_wr_valid;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    // Register 0 is never written, so storage at index 0 stays at its reset
    // value of zero for the whole run.
    assign w_wr_valid = WrEn && (WrAddr != '0);

    // NOTE: the whole array is reset because software relies on every
    // register reading zero after reset; this keeps the array in flops
    // rather than a RAM macro, which is expected for a 32-entry file.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_valid) begin
            // NOTE: sequential state always uses non-blocking assignment so
            // every flop samples pre-edge values regardless of block order.
            r_mem[WrAddr] <= WrData;
        end
    end

    // Read priority: reset or index 0 -> zero, then same-cycle write bypass,
    // then stored value. Reset gating is needed on the bypass path only; the
    // storage itself is already zero while Reset is low.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first
        // so no path through the block can infer a latch.
        w_rd_a = r_mem[RdAddrA];
        if (!Reset || (RdAddrA == '0)) begin
            w_rd_a = '0;
        end else if (WrEn && (WrAddr == RdAddrA)) begin
            w_rd_a = WrData;
        end
    end

    always_comb begin
        w_rd_b = r_mem[RdAddrB];
        if (!Reset || (RdAddrB == '0)) begin
            w_rd_b = '0;
        end else if (WrEn && (WrAddr == RdAddrB)) begin
            w_rd_b = WrData;
        end
    end

    assign RdDataA = w_rd_a;
    assign RdDataB = w_rd_b;

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
//   Directed and randomized stimulus for register_file. Expected read data
//   comes from an architectural model: an array of 32 register values plus
//   the read rules (zero register, same-cycle forwarding, reset forces zero).
//   Inputs change mid-cycle; outputs are sampled 1 ns after input changes,
//   well away from the rising clock edge.
// ---------------------------------------------------------------------------
module tb_register_file;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              Clk;
    logic              Reset;
    logic              WrEn;
    logic [ADDR_W-1:0] WrAddr;
    logic [WIDTH-1:0]  WrData;
    logic [ADDR_W-1:0] RdAddrA;
    logic [ADDR_W-1:0] RdAddrB;
    logic [WIDTH-1:0]  RdDataA;
    logic [WIDTH-1:0]  RdDataB;

    int pass_count  = 0;
    int check_count = 0;

    logic [WIDTH-1:0] model [DEPTH];

    register_file #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .WrEn    (WrEn),
        .WrAddr  (WrAddr),
        .WrData  (WrData),
        .RdAddrA (RdAddrA),
        .RdAddrB (RdAddrB),
        .RdDataA (RdDataA),
        .RdDataB (RdDataB)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] observed,
                         input logic [WIDTH-1:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    endtask

    // What the architecture says a read of 'addr' returns right now.
    function automatic logic [WIDTH-1:0] arch_read(input logic [ADDR_W-1:0] addr);
        if (!Reset)                       return '0;
        if (addr == 0)                    return '0;
        if (WrEn && WrAddr == addr)       return WrData;
        return model[addr];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic drive(input logic en, input logic [ADDR_W-1:0] wa,
                         input logic [WIDTH-1:0] wd,
                         input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb);
        WrEn    = en;
        WrAddr  = wa;
        WrData  = wd;
        RdAddrA = ra;
        RdAddrB = rb;
        #1;
    endtask

    // Compare both ports against the model for the current inputs.
    task automatic check_ports(input string tag);
        check({tag, "/A"}, RdDataA, arch_read(RdAddrA));
        check({tag, "/B"}, RdDataB, arch_read(RdAddrB));
    endtask

    // Advance one rising edge; the model commits what the inputs requested.
    // Returns 2 ns after the edge so the next drive stays clear of it.
    task automatic tick();
        logic             do_wr;
        logic [ADDR_W-1:0] wa;
        logic [WIDTH-1:0]  wd;
        do_wr = Reset && WrEn && (WrAddr != 0);
        wa    = WrAddr;
        wd    = WrData;
        @(posedge Clk);
        if (do_wr) model[wa] = wd;
        #2;
    endtask

    task automatic write_reg(input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd);
        drive(1'b1, wa, wd, 5'd0, 5'd0);
        tick();
    endtask

    initial begin
        Reset = 1'b0;
        clear_model();
        drive(1'b0, 5'd0, '0, 5'd0, 5'd0);

        // Reset state: reads are zero even with a matching write presented.
        drive(1'b1, 5'd4, 32'h1234_5678, 5'd4, 5'd17);
        check("reset_bypass_gated", RdDataA, 32'h0);
        check("reset_read_b", RdDataB, 32'h0);
        tick();
        check("reset_no_write", RdDataA, 32'h0);
        Reset = 1'b1;
        drive(1'b0, 5'd0, '0, 5'd4, 5'd17);
        check("post_reset_r4", RdDataA, 32'h0);
        check("post_reset_r17", RdDataB, 32'h0);

        // 1. Reset asserted mid-cycle clears immediately.
        write_reg(5'd5, 32'h6748_0FAC);
        write_reg(5'd9, 32'h1110_1110);
        drive(1'b0, 5'd0, '0, 5'd5, 5'd9);
        check("r5_written", RdDataA, 32'h6748_0FAC);
        check("r9_written", RdDataB, 32'h1110_1110);
        Reset = 1'b0;
        clear_model();
        #1;
        check("async_clear_a", RdDataA, 32'h0);
        check("async_clear_b", RdDataB, 32'h0);
        #1;
        Reset = 1'b1;
        #1;
        check("released_r5", RdDataA, 32'h0);
        check("released_r9", RdDataB, 32'h0);
        tick();

        // 2. Fill r1..r31 with a distinct pattern, then sweep both ports.
        for (int i = 1; i < DEPTH; i++) begin
            write_reg(5'(i), 32'hDEAD_BEEF ^ 32'(i));
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 5'd0, '0, 5'(i), 5'(DEPTH - 1 - i));
            check($sformatf("sweep_a_r%0d", i), RdDataA,
                  (i == 0) ? 32'h0 : (32'hDEAD_BEEF ^ 32'(i)));
            check($sformatf("sweep_b_r%0d", DEPTH - 1 - i), RdDataB,
                  (i == DEPTH - 1) ? 32'h0 : (32'hDEAD_BEEF ^ 32'(DEPTH - 1 - i)));
        end

        // 3. Writes to r0 are discarded, bypass included.
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        check("r0_bypass_a", RdDataA, 32'h0);
        tick();
        drive(1'b0, 5'd0, '0, 5'd0, 5'd0);
        check("r0_after_a", RdDataA, 32'h0);
        check("r0_after_b", RdDataB, 32'h0);

        // 4. Same-cycle bypass, then storage holds the new value.
        write_reg(5'd7, 32'h1234_5678);
        drive(1'b1, 5'd7, 32'hCAFE_BABE, 5'd7, 5'd8);
        check("bypass_r7", RdDataA, 32'hCAFE_BABE);
        check("bypass_other", RdDataB, 32'hDEAD_BEEF ^ 32'd8);
        tick();
        drive(1'b0, 5'd7, 32'h0, 5'd7, 5'd7);
        check("r7_stored_a", RdDataA, 32'hCAFE_BABE);
        check("r7_stored_b", RdDataB, 32'hCAFE_BABE);

        // 5. WrEn low: nothing written, nothing forwarded.
        write_reg(5'd3, 32'h8765_4321);
        drive(1'b0, 5'd3, 32'hAABB_CCDD, 5'd3, 5'd3);
        check("no_en_bypass", RdDataA, 32'h8765_4321);
        for (int i = 0; i < 3; i++) tick();
        check("no_en_held_a", RdDataA, 32'h8765_4321);
        check("no_en_held_b", RdDataB, 32'h8765_4321);

        // 6. Both ports on the register being written.
        drive(1'b1, 5'd12, 32'h0000_0001, 5'd12, 5'd12);
        check("dual_bypass_a", RdDataA, 32'h0000_0001);
        check("dual_bypass_b", RdDataB, 32'h0000_0001);
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), $urandom(),
                  5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)));
            // Bias some reads onto the write address to exercise forwarding.
            if ($urandom_range(3, 0) == 0) begin
                RdAddrA = WrAddr;
                #1;
            end
            check_ports($sformatf("rand%0d", n));
            tick();
        end

        // Final full sweep of storage.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 5'd0, '0, 5'(i), 5'(i));
            check_ports($sformatf("final_r%0d", i));
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
